mux_arb: RTL and testbench

MUX_ARB -- requirements
Module: mux_arb

---
 rtl/mux_arb.sv | 92 +++++++++
 tb/tb_mux_arb.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb.sv
// N-channel input multiplexer/arbiter feeding a single registered output entry.
// Selection is either direct (sel) or round-robin over the valid inputs.
module mux_arb #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int MODE  = 0,
    localparam int SW   = ($clog2(NCH) < 1) ? 1 : $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [SW-1:0]        sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SW-1:0]        out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // Handshake: a word moves across a port on any rising edge where that
    // port's valid and ready are both high; valid never waits on ready.
    logic             load;
    logic             hit;
    logic             xfer;
    logic [SW-1:0]    gnt;
    logic [SW-1:0]    ptr;
    logic [WIDTH-1:0] gnt_data;

    assign load = !out_valid || out_ready;
    assign xfer = hit && load && !rst;

    always_comb begin
        int idx;
        hit = 1'b0;
        gnt = '0;
        idx = 0;
        if (MODE == 0) begin
            // Out-of-range sel values match no channel, so they never grant.
            for (int i = 0; i < NCH; i++) begin
                if (sel == SW'(i) && in_valid[i]) begin
                    hit = 1'b1;
                    gnt = SW'(i);
                end
            end
        end else begin
            // Search ptr+1 .. ptr (inclusive) with an explicit wrap so NCH
            // need not be a power of two.
            for (int k = 1; k <= NCH; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NCH) idx = idx - NCH;
                if (!hit && in_valid[idx]) begin
                    hit = 1'b1;
                    gnt = SW'(idx);
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            in_ready[i] = xfer && (gnt == SW'(i));
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt == SW'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                out_data  <= gnt_data;
                out_ch    <= gnt;
                out_valid <= 1'b1;
                if (MODE == 1) ptr <= gnt;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_arb.sv
// Directed bench for mux_arb: direct select, round-robin (power-of-two and
// odd channel counts), backpressure and asynchronous reset.
module tb_mux_arb;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    // a: MODE 0, NCH 4
    logic [127:0] a_in_data;
    logic [3:0]   a_in_valid, a_in_ready;
    logic [1:0]   a_sel, a_out_ch;
    logic [31:0]  a_out_data;
    logic         a_out_valid, a_out_ready;
    // b: MODE 1, NCH 4
    logic [127:0] b_in_data;
    logic [3:0]   b_in_valid, b_in_ready;
    logic [1:0]   b_sel, b_out_ch;
    logic [31:0]  b_out_data;
    logic         b_out_valid, b_out_ready;
    // c: MODE 1, NCH 3
    logic [95:0]  c_in_data;
    logic [2:0]   c_in_valid, c_in_ready;
    logic [1:0]   c_sel, c_out_ch;
    logic [31:0]  c_out_data;
    logic         c_out_valid, c_out_ready;
    // d: MODE 0, NCH 3
    logic [95:0]  d_in_data;
    logic [2:0]   d_in_valid, d_in_ready;
    logic [1:0]   d_sel, d_out_ch;
    logic [31:0]  d_out_data;
    logic         d_out_valid, d_out_ready;

    mux_arb #(.WIDTH(32), .NCH(4), .MODE(0)) u_a (
        .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data),
        .out_ch(a_out_ch), .out_valid(a_out_valid), .out_ready(a_out_ready));
    mux_arb #(.WIDTH(32), .NCH(4), .MODE(1)) u_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data),
        .out_ch(b_out_ch), .out_valid(b_out_valid), .out_ready(b_out_ready));
    mux_arb #(.WIDTH(32), .NCH(3), .MODE(1)) u_c (
        .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .sel(c_sel), .out_data(c_out_data),
        .out_ch(c_out_ch), .out_valid(c_out_valid), .out_ready(c_out_ready));
    mux_arb #(.WIDTH(32), .NCH(3), .MODE(0)) u_d (
        .clk(clk), .rst(rst), .in_data(d_in_data), .in_valid(d_in_valid),
        .in_ready(d_in_ready), .sel(d_sel), .out_data(d_out_data),
        .out_ch(d_out_ch), .out_valid(d_out_valid), .out_ready(d_out_ready));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        a_in_data = '0; a_in_valid = 4'b1111; a_sel = 2'd0; a_out_ready = 1'b1;
        b_in_data = '0; b_in_valid = 4'b1111; b_sel = 2'd0; b_out_ready = 1'b1;
        c_in_data = '0; c_in_valid = 3'b000;  c_sel = 2'd0; c_out_ready = 1'b1;
        d_in_data = '0; d_in_valid = 3'b000;  d_sel = 2'd0; d_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (a_in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_a_in_ready got %b want 0000", a_in_ready); end
        n_cmp++;
        if (b_in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_b_in_ready got %b want 0000", b_in_ready); end
        n_cmp++;
        if ({a_out_valid, a_out_data, a_out_ch} !== 35'd0) begin n_err++; $display("FAIL reset_a_out got v=%b d=%h ch=%0d want 0", a_out_valid, a_out_data, a_out_ch); end
        n_cmp++;
        if ({b_out_valid, b_out_data, b_out_ch} !== 35'd0) begin n_err++; $display("FAIL reset_b_out got v=%b d=%h ch=%0d want 0", b_out_valid, b_out_data, b_out_ch); end
        a_in_valid = 4'b0000;
        b_in_valid = 4'b0000;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_direct();
        a_sel = 2'd2;
        a_in_valid = 4'b0100;
        a_in_data[2*32 +: 32] = 32'hDEADBEEF;
        a_out_ready = 1'b1;
        #1;
        n_cmp++;
        if (a_in_ready !== 4'b0100) begin n_err++; $display("FAIL direct_in_ready got %b want 0100", a_in_ready); end
        @(negedge clk);
        a_in_valid = 4'b0000;
        n_cmp++;
        if (a_out_valid !== 1'b1 || a_out_data !== 32'hDEADBEEF || a_out_ch !== 2'd2) begin
            n_err++; $display("FAIL direct_out got v=%b d=%h ch=%0d want 1 deadbeef 2", a_out_valid, a_out_data, a_out_ch);
        end
        @(negedge clk);
        n_cmp++;
        if (a_out_valid !== 1'b0 || a_out_data !== 32'hDEADBEEF || a_out_ch !== 2'd2) begin
            n_err++; $display("FAIL direct_drain got v=%b d=%h ch=%0d want 0 deadbeef 2", a_out_valid, a_out_data, a_out_ch);
        end
    endtask

    task automatic test_sel_oob();
        d_sel = 2'd3;
        d_in_valid = 3'b111;
        d_in_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        d_out_ready = 1'b1;
        #1;
        n_cmp++;
        if (d_in_ready !== 3'b000) begin n_err++; $display("FAIL oob_in_ready got %b want 000", d_in_ready); end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (d_out_valid !== 1'b0) begin n_err++; $display("FAIL oob_out_valid got %b want 0", d_out_valid); end
        d_in_valid = 3'b000;
    endtask

    task automatic test_backpressure();
        int bad_rdy;
        int bad_out;
        a_sel = 2'd1;
        a_in_valid = 4'b0010;
        a_in_data[1*32 +: 32] = 32'h12345678;
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        a_in_data[1*32 +: 32] = 32'hCAFEF00D;
        bad_rdy = 0;
        bad_out = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (a_in_ready !== 4'b0000) bad_rdy++;
            if (a_out_valid !== 1'b1 || a_out_data !== 32'h12345678 || a_out_ch !== 2'd1) bad_out++;
            @(negedge clk);
        end
        n_cmp++;
        if (bad_rdy != 0) begin n_err++; $display("FAIL bp_in_ready got %0d cycles with ready high want 0", bad_rdy); end
        n_cmp++;
        if (bad_out != 0) begin n_err++; $display("FAIL bp_hold got %0d unstable cycles want 0 (last d=%h)", bad_out, a_out_data); end
        a_out_ready = 1'b1;
        #1;
        n_cmp++;
        if (a_in_ready !== 4'b0010) begin n_err++; $display("FAIL bp_release_ready got %b want 0010", a_in_ready); end
        @(negedge clk);
        a_in_valid = 4'b0000;
        n_cmp++;
        if (a_out_valid !== 1'b1 || a_out_data !== 32'hCAFEF00D || a_out_ch !== 2'd1) begin
            n_err++; $display("FAIL bp_replace got v=%b d=%h ch=%0d want 1 cafef00d 1", a_out_valid, a_out_data, a_out_ch);
        end
        @(negedge clk);
    endtask

    task automatic test_rr();
        int exp_g [5] = '{1, 2, 3, 0, 1};
        logic [3:0] exp_r;
        for (int i = 0; i < 4; i++) b_in_data[i*32 +: 32] = 32'hB000_0000 + i;
        b_in_valid = 4'b1111;
        b_out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_r = 4'b0001 << exp_g[k];
            #1;
            n_cmp++;
            if (b_in_ready !== exp_r) begin n_err++; $display("FAIL rr_ready[%0d] got %b want %b", k, b_in_ready, exp_r); end
            @(negedge clk);
            n_cmp++;
            if (b_out_valid !== 1'b1 || b_out_ch !== 2'(exp_g[k]) || b_out_data !== 32'hB000_0000 + exp_g[k]) begin
                n_err++; $display("FAIL rr_out[%0d] got v=%b ch=%0d d=%h want ch=%0d", k, b_out_valid, b_out_ch, b_out_data, exp_g[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        // b still has all channels valid and a word held from test_rr.
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (b_out_valid !== 1'b0 || b_out_data !== 32'd0 || b_out_ch !== 2'd0) begin
            n_err++; $display("FAIL async_rst got v=%b d=%h ch=%0d want 0 0 0", b_out_valid, b_out_data, b_out_ch);
        end
        n_cmp++;
        if (b_in_ready !== 4'b0000) begin n_err++; $display("FAIL async_rst_ready got %b want 0000", b_in_ready); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (b_in_ready !== 4'b0010) begin n_err++; $display("FAIL post_rst_ready got %b want 0010", b_in_ready); end
        @(negedge clk);
        n_cmp++;
        if (b_out_valid !== 1'b1 || b_out_ch !== 2'd1 || b_out_data !== 32'hB000_0001) begin
            n_err++; $display("FAIL post_rst_out got v=%b ch=%0d d=%h want 1 1 b0000001", b_out_valid, b_out_ch, b_out_data);
        end
        b_in_valid = 4'b0000;
    endtask

    task automatic test_rr_npot();
        int exp_g [4] = '{2, 0, 2, 0};
        logic [2:0] exp_r;
        c_in_data = {32'hC000_0002, 32'hC000_0001, 32'hC000_0000};
        c_in_valid = 3'b101;
        c_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_r = 3'b001 << exp_g[k];
            #1;
            n_cmp++;
            if (c_in_ready !== exp_r) begin n_err++; $display("FAIL npot_ready[%0d] got %b want %b", k, c_in_ready, exp_r); end
            @(negedge clk);
            n_cmp++;
            if (c_out_valid !== 1'b1 || c_out_ch !== 2'(exp_g[k]) || c_out_data !== 32'hC000_0000 + exp_g[k]) begin
                n_err++; $display("FAIL npot_out[%0d] got v=%b ch=%0d d=%h want ch=%0d", k, c_out_valid, c_out_ch, c_out_data, exp_g[k]);
            end
        end
        c_in_valid = 3'b000;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_direct();
        test_sel_oob();
        test_backpressure();
        test_rr();
        test_async_reset();
        test_rr_npot();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
